// File: rtl/avalon_mm_pkg.sv
// Shared defaults, address layout and FSM encoding for the Avalon-MM responder.
package avalon_mm_pkg;

    localparam int AVMM_ADDR_W = 64;
    localparam int AVMM_DATA_W = 512;
    localparam int AVMM_BE_W   = AVMM_DATA_W / 8;
    // Byte offset bits inside one DATA_W word; must be zero for a legal address.
    localparam int ADDR_LSB    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } avmm_state_t;

endpackage

// File: rtl/avmm_be_ram.sv
// DEPTH x DATA_W storage: byte-enable synchronous write, asynchronous read, cleared on reset.
module avmm_be_ram
    import avalon_mm_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = AVMM_DATA_W,
    parameter int BE_W   = AVMM_BE_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem <= '0;
        end else if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/avalon_mm_responder.sv
// Avalon-MM slave with fixed wait states, byte-enable storage, illegal-address
// detection, sticky error flag and saturating transfer counters.
module avalon_mm_responder
    import avalon_mm_pkg::*;
#(
    parameter int ADDR_W   = AVMM_ADDR_W,
    parameter int DATA_W   = AVMM_DATA_W,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   avs_address_i,
    input  logic                avs_read_i,
    input  logic                avs_write_i,
    input  logic [DATA_W/8-1:0] avs_byteenable_i,
    input  logic [DATA_W-1:0]   avs_writedata_i,
    input  logic                avs_lock_i,
    output logic [DATA_W-1:0]   avs_readdata_o,
    output logic                avs_waitrequest_o,
    output logic                locked_o,
    output logic                err_o,
    input  logic                err_clr_i,
    output logic [31:0]         rd_cnt_o,
    output logic [31:0]         wr_cnt_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    // Counter value on the last WAIT cycle; unused when WAIT_CYC is 0.
    localparam logic [3:0] WLAST = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    avmm_state_t        r_state, w_state_nxt;
    logic [3:0]         r_wcnt, w_wcnt_nxt;
    logic               r_locked, r_err;
    logic [31:0]        r_rd_cnt, r_wr_cnt;

    logic               w_req, w_ack, w_abort, w_illegal;
    logic               w_do_wr, w_do_rd, w_err_set;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_ram_rd;

    assign w_req     = avs_read_i | avs_write_i;
    assign w_ack     = (r_state == ST_ACK);
    assign w_idx     = avs_address_i[ADDR_LSB +: IDX_W];
    assign w_illegal = (|avs_address_i[ADDR_LSB-1:0]) |
                       ((avs_address_i >> (ADDR_LSB + IDX_W)) != '0);

    // Write wins when both strobes are high; the read is neither done nor counted.
    assign w_do_wr   = w_ack & avs_write_i;
    assign w_do_rd   = w_ack & avs_read_i & ~avs_write_i;
    assign w_err_set = w_abort | (w_ack & w_req & w_illegal);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wcnt_nxt = '0;
                if (w_req) w_state_nxt = (WAIT_CYC > 0) ? ST_WAIT : ST_ACK;
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = '0;
                    w_abort     = 1'b1;
                end else if (r_wcnt == WLAST) begin
                    w_state_nxt = ST_ACK;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt  = r_wcnt + 4'd1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_ack) r_locked <= avs_lock_i;
            // A new error outranks a simultaneous clear.
            if (w_err_set)      r_err <= 1'b1;
            else if (err_clr_i) r_err <= 1'b0;
            if (w_do_rd && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_do_wr && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    avmm_be_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (w_do_wr & ~w_illegal),
        .i_addr  (w_idx),
        .i_be    (avs_byteenable_i),
        .i_wdata (avs_writedata_i),
        .o_rdata (w_ram_rd)
    );

    assign avs_readdata_o    = w_illegal ? '0 : w_ram_rd;
    assign avs_waitrequest_o = ~w_ack;
    assign locked_o          = r_locked;
    assign err_o             = r_err;
    assign rd_cnt_o          = r_rd_cnt;
    assign wr_cnt_o          = r_wr_cnt;

endmodule

// File: tb/tb_avalon_mm_responder.sv
// Directed bench for avalon_mm_responder: two instances (1 and 3 wait states),
// read data checked through a scoreboard fed from a reference memory model.
module tb_avalon_mm_responder;

    logic         clk = 1'b0;
    logic         rstn;
    logic [63:0]  addr;
    logic [511:0] wdata;
    logic [63:0]  be;
    logic         lock, err_clr;
    logic         a_rd, a_wr, b_rd, b_wr;

    logic [511:0] rdata1, rdata3;
    logic         wreq1, wreq3, locked1, locked3, err1, err3;
    logic [31:0]  rdcnt1, rdcnt3, wrcnt1, wrcnt3;

    int errors = 0;
    int checks = 0;
    logic [511:0] sb[$];
    logic [511:0] mdl[2][16];

    always #5 clk = ~clk;

    avalon_mm_responder #(.ADDR_W(64), .DATA_W(512), .DEPTH(16), .WAIT_CYC(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .avs_address_i(addr), .avs_read_i(a_rd), .avs_write_i(a_wr),
        .avs_byteenable_i(be), .avs_writedata_i(wdata), .avs_lock_i(lock),
        .avs_readdata_o(rdata1), .avs_waitrequest_o(wreq1), .locked_o(locked1), .err_o(err1),
        .err_clr_i(err_clr), .rd_cnt_o(rdcnt1), .wr_cnt_o(wrcnt1));

    avalon_mm_responder #(.ADDR_W(64), .DATA_W(512), .DEPTH(16), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .avs_address_i(addr), .avs_read_i(b_rd), .avs_write_i(b_wr),
        .avs_byteenable_i(be), .avs_writedata_i(wdata), .avs_lock_i(lock),
        .avs_readdata_o(rdata3), .avs_waitrequest_o(wreq3), .locked_o(locked3), .err_o(err3),
        .err_clr_i(err_clr), .rd_cnt_o(rdcnt3), .wr_cnt_o(wrcnt3));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [63:0] a);
        return (a[5:0] == 6'd0) && (a[63:10] == 54'd0);
    endfunction

    function automatic logic [511:0] mdl_read(input int s, input logic [63:0] a);
        return legal(a) ? mdl[s][a[9:6]] : 512'd0;
    endfunction

    function automatic logic wreq_of(input int s);
        return (s == 0) ? wreq1 : wreq3;
    endfunction

    function automatic logic [511:0] rdata_of(input int s);
        return (s == 0) ? rdata1 : rdata3;
    endfunction

    task automatic mdl_clear();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++) mdl[s][w] = '0;
    endtask

    // One transfer: drive just after a rising edge, poll waitrequest on falling
    // edges (poll index = cycle number), release after the acknowledging edge.
    task automatic xfer(input int s, input logic rd, input logic wr, input logic [63:0] a,
                        input logic [511:0] d, input logic [63:0] b, input logic lk,
                        output int lat);
        logic [511:0] exp;
        @(posedge clk); #1;
        addr = a; wdata = d; be = b; lock = lk;
        if (s == 0) begin a_rd = rd; a_wr = wr; end
        else        begin b_rd = rd; b_wr = wr; end
        if (rd && !wr) sb.push_back(mdl_read(s, a));
        lat = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (!wreq_of(s)) begin
                lat = k;
                if (rd && !wr) begin
                    exp = sb.pop_front();
                    chk("rdata", rdata_of(s), exp);
                end
                break;
            end
        end
        @(posedge clk); #1;
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        if (lat < 0 && rd && !wr) void'(sb.pop_front());
        if (lat >= 0 && wr && legal(a))
            for (int i = 0; i < 64; i++)
                if (b[i]) mdl[s][a[9:6]][i*8 +: 8] = d[i*8 +: 8];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acks;
        logic [511:0] rnd;
        logic [63:0]  rbe;

        rstn = 0; addr = '0; wdata = '0; be = '0; lock = 0; err_clr = 0;
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        mdl_clear();
        #12;
        chk("rst_wreq1", 512'(wreq1), 512'd1);
        chk("rst_locked1", 512'(locked1), 512'd0);
        chk("rst_err1", 512'(err1), 512'd0);
        chk("rst_rdcnt1", 512'(rdcnt1), 512'd0);
        chk("rst_wrcnt1", 512'(wrcnt1), 512'd0);
        chk("rst_wreq3", 512'(wreq3), 512'd1);
        @(negedge clk); rstn = 1;

        // Full write, 1 wait state: acknowledge in cycle 2 only.
        xfer(0, 0, 1, 64'h40, {64{8'hA5}}, '1, 0, lat);
        chk("wr_lat", 512'(lat), 512'd2);
        @(negedge clk);
        chk("wreq_after_ack", 512'(wreq1), 512'd1);
        chk("wrcnt_1", 512'(wrcnt1), 512'd1);

        xfer(0, 1, 0, 64'h40, '0, '0, 0, lat);
        chk("rd_lat", 512'(lat), 512'd2);
        chk("rdcnt_1", 512'(rdcnt1), 512'd1);

        // Byte-0-only write leaves the other 63 bytes alone.
        xfer(0, 0, 1, 64'h40, 512'h3C, 64'h1, 0, lat);
        xfer(0, 1, 0, 64'h40, '0, '0, 0, lat);

        // Read and write together: only the write happens.
        for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
        xfer(0, 1, 1, 64'h80, rnd, '1, 0, lat);
        chk("rw_wrcnt", 512'(wrcnt1), 512'd3);
        chk("rw_rdcnt", 512'(rdcnt1), 512'd2);
        xfer(0, 1, 0, 64'h80, '0, '0, 0, lat);

        // Random partial write.
        for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
        rbe = {$urandom, $urandom};
        xfer(0, 0, 1, 64'hC0, rnd, rbe, 0, lat);
        xfer(0, 1, 0, 64'hC0, '0, '0, 0, lat);

        // Misaligned and out-of-range reads return zero and flag an error.
        xfer(0, 1, 0, 64'h41, '0, '0, 0, lat);
        chk("misalign_lat", 512'(lat), 512'd2);
        chk("misalign_err", 512'(err1), 512'd1);
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
        @(negedge clk);
        chk("err_clr", 512'(err1), 512'd0);
        xfer(0, 1, 0, 64'h400, '0, '0, 0, lat);
        chk("range_err", 512'(err1), 512'd1);
        chk("illegal_rdcnt", 512'(rdcnt1), 512'd6);
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;

        // Out-of-range write would alias word 1 if not dropped.
        xfer(0, 0, 1, 64'h440, {64{8'hFF}}, '1, 0, lat);
        chk("illegal_wr_err", 512'(err1), 512'd1);
        chk("illegal_wrcnt", 512'(wrcnt1), 512'd5);
        xfer(0, 1, 0, 64'h40, '0, '0, 0, lat);

        // Clear held across an error event: the set must win.
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1;
        xfer(0, 1, 0, 64'h41, '0, '0, 0, lat);
        chk("set_beats_clr", 512'(err1), 512'd1);
        err_clr = 0;

        // Lock status follows the last acknowledged transfer.
        xfer(0, 0, 1, 64'h100, 512'h1234, '1, 1, lat);
        chk("locked_hi", 512'(locked1), 512'd1);
        xfer(0, 1, 0, 64'h100, '0, '0, 0, lat);
        chk("locked_lo", 512'(locked1), 512'd0);

        // Three wait states.
        for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
        xfer(1, 0, 1, 64'h40, rnd, '1, 0, lat);
        chk("w3_wr_lat", 512'(lat), 512'd4);
        xfer(1, 1, 0, 64'h40, '0, '0, 0, lat);
        chk("w3_rd_lat", 512'(lat), 512'd4);

        // Read dropped while waiting: never acknowledged, error raised.
        acks = 0;
        @(posedge clk); #1 addr = 64'h80; b_rd = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!wreq3) acks++;
            if (k == 2) begin @(posedge clk); #1 b_rd = 0; end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!wreq3) acks++;
        end
        chk("drop_no_ack", 512'(acks), 512'd0);
        chk("drop_err", 512'(err3), 512'd1);
        chk("drop_rdcnt", 512'(rdcnt3), 512'd1);

        // Reset in the middle of a write's wait period.
        @(posedge clk); #1 addr = 64'h40; wdata = {64{8'h5A}}; be = '1; b_wr = 1;
        @(negedge clk); @(negedge clk);
        rstn = 0; #1;
        chk("rst_mid_wreq", 512'(wreq3), 512'd1);
        chk("rst_mid_err", 512'(err3), 512'd0);
        b_wr = 0;
        mdl_clear();
        @(negedge clk); rstn = 1;
        chk("rst_mid_wrcnt1", 512'(wrcnt1), 512'd0);
        xfer(1, 1, 0, 64'h40, '0, '0, 0, lat);
        chk("rst_mid_rdlat", 512'(lat), 512'd4);
        xfer(0, 1, 0, 64'h80, '0, '0, 0, lat);

        chk("sb_empty", 512'(sb.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
